// File: rtl/inst_fetch.sv
// inst_fetch: owns the PC, runs a one-outstanding fetch to instruction memory
// and holds the fetched word in a one-entry buffer for decode.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic [6:0]  if_opcode
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
  localparam logic [31:0] ALIGN = 32'hFFFF_FFFC;
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, addr_q, addr_d, inst_q, inst_d, ipc_q, ipc_d;
  logic        full_q, full_d, drop_q, drop_d;
  logic        xfer;
  assign if_valid  = full_q & ~redirect_valid;
  assign xfer      = if_valid & if_ready;
  assign imem_req  = (state_q == REQ);
  assign imem_addr = addr_q;
  assign if_inst   = inst_q;
  assign if_pc     = ipc_q;
  assign if_opcode = inst_q[6:0];
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    full_d  = xfer ? 1'b0 : full_q;
    drop_d  = drop_q;
    case (state_q)
      IDLE: state_d = (!full_q || xfer) ? REQ : IDLE;
      REQ:  state_d = imem_gnt ? WAIT : REQ;
      WAIT: if (imem_rvalid) begin
        state_d = IDLE;
        drop_d  = 1'b0;
        if (!drop_q && !redirect_valid) begin
          inst_d = imem_rdata;
          ipc_d  = pc_q;
          full_d = 1'b1;
          pc_d   = pc_q + 32'd4;
        end
      end
      default: state_d = IDLE;
    endcase
    // A redirect overrides any load; an in-flight request is marked for discard.
    if (redirect_valid) begin
      pc_d   = redirect_pc & ALIGN;
      full_d = 1'b0;
      inst_d = NOP_INST;
      if (state_q == REQ || (state_q == WAIT && !imem_rvalid)) drop_d = 1'b1;
    end
    if (state_q == IDLE && state_d == REQ) addr_d = pc_d;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC & ALIGN;
      addr_q  <= RESET_PC & ALIGN;
      inst_q  <= NOP_INST;
      ipc_q   <= RESET_PC & ALIGN;
      full_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
      full_q  <= full_d;
      drop_q  <= drop_d;
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed fetch scenarios; delivered instructions are checked
// against a scoreboard queue by a monitor on every decode transfer.
module tb_inst_fetch;
  logic        clk, rst_n;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid, if_ready;
  logic [31:0] if_inst, if_pc;
  logic [6:0]  if_opcode;
  int          checks = 0, errors = 0, cyc = 0;
  logic [63:0] sb[$];
  int          rise_cyc[$];
  logic        prev_valid = 1'b0;

  inst_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst),
    .if_pc(if_pc), .if_opcode(if_opcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every decode transfer must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && if_valid && !prev_valid) rise_cyc.push_back(cyc);
    prev_valid <= rst_n && if_valid;
    if (rst_n && if_valid && if_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_xfer: got pc %h inst %h expected none", if_pc, if_inst);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("xfer_pc", if_pc, e[63:32]);
        chk("xfer_inst", if_inst, e[31:0]);
        chk("xfer_opcode", {25'd0, if_opcode}, {25'd0, e[6:0]});
      end
    end
  end

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 20) begin
      step();
      n++;
    end
    chk("req_seen", {31'd0, imem_req}, 32'd1);
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] data,
                       input int gnt_wait, input bit push);
    wait_req();
    chk("req_addr", imem_addr, addr);
    for (int i = 0; i < gnt_wait; i++) begin
      imem_gnt = 1'b0;
      step();
      chk("stall_req", {31'd0, imem_req}, 32'd1);
      chk("stall_addr", imem_addr, addr);
    end
    imem_gnt = 1'b1;
    step();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    if (push) sb.push_back({addr, data});
    step();
    imem_rvalid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; if_ready = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_inst", if_inst, 32'h0000_0013);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_pc", if_pc, 32'h0);
    step();
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    chk("first_valid", {31'd0, if_valid}, 32'd0);
    // Sequential fetch with decode always ready.
    fetch(32'h0, 32'h0050_0093, 0, 1);
    fetch(32'h4, 32'h00A0_0113, 0, 1);
    // Backpressure: item at 0x4 held for 5 cycles.
    if_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", {31'd0, if_valid}, 32'd1);
      chk("bp_inst", if_inst, 32'h00A0_0113);
      chk("bp_pc", if_pc, 32'h4);
      chk("bp_req", {31'd0, imem_req}, 32'd0);
    end
    if_ready = 1'b1;
    step();
    // Redirect while buffer holds pc 0x8.
    if_ready = 1'b0;
    fetch(32'h8, 32'h0030_0193, 0, 0);
    chk("full_valid", {31'd0, if_valid}, 32'd1);
    chk("full_pc", if_pc, 32'h8);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    #1;
    chk("squash_valid", {31'd0, if_valid}, 32'd0);
    step();
    redirect_valid = 1'b0;
    chk("flush_inst", if_inst, 32'h0000_0013);
    chk("flush_valid", {31'd0, if_valid}, 32'd0);
    if_ready = 1'b1;
    fetch(32'h200, 32'h0070_0213, 0, 1);
    // Redirect while waiting for rvalid.
    wait_req();
    chk("wait_addr", imem_addr, 32'h204);
    imem_gnt = 1'b1;
    step();
    imem_gnt       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step();
    redirect_valid = 1'b0;
    step();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    chk("drop_valid", {31'd0, if_valid}, 32'd0);
    chk("drop_inst", if_inst, 32'h0000_0013);
    fetch(32'h100, 32'h0080_0293, 0, 1);
    // Redirect in REQ before gnt: old address is still requested.
    wait_req();
    chk("reqredir_addr0", imem_addr, 32'h104);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    step();
    redirect_valid = 1'b0;
    chk("reqredir_req", {31'd0, imem_req}, 32'd1);
    chk("reqredir_addr1", imem_addr, 32'h104);
    imem_gnt = 1'b1;
    step();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0BAD_0BAD;
    step();
    imem_rvalid = 1'b0;
    chk("reqredir_valid", {31'd0, if_valid}, 32'd0);
    if_ready = 1'b0;
    fetch(32'h300, 32'h00C0_0493, 0, 0);
    chk("r300_inst", if_inst, 32'h00C0_0493);
    // Wrap with a stalled grant.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    if_ready = 1'b1;
    fetch(32'hFFFF_FFFC, 32'h0090_0313, 4, 1);
    fetch(32'h0, 32'h00A0_0393, 0, 1);
    // Reset mid-transaction: a late rvalid is ignored.
    wait_req();
    chk("pre_rst_addr", imem_addr, 32'h4);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0BAD_F00D;
    step();
    imem_rvalid = 1'b0;
    chk("mid_rst_valid", {31'd0, if_valid}, 32'd0);
    chk("mid_rst_req", {31'd0, imem_req}, 32'd1);
    chk("mid_rst_addr", imem_addr, 32'h0);
    fetch(32'h0, 32'h00B0_0413, 0, 1);
    repeat (3) step();
    chk("sb_empty", sb.size(), 32'd0);
    if (rise_cyc.size() >= 2) chk("throughput_gap", rise_cyc[1] - rise_cyc[0], 32'd3);
    else chk("valid_rises", rise_cyc.size(), 32'd2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
